// File: rtl/stage_mem_pkg.sv
// stage_mem_pkg: constants shared by the memory-access stage.
// Holds the RV32I opcodes the pipeline refers to, funct3 encodings for
// loads/stores and the stage FSM state encoding.
package stage_mem_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_e;

endpackage

// File: rtl/stage_mem_load_store_align.sv
// load_store_align: combinational byte-lane logic for the memory stage.
// Ports:
//   funct3_i   access size/sign encoding
//   addr_lo_i  effective address bits [1:0]
//   st_dat_i   store data from rs2
//   rd_dat_i   raw bus read data
//   sel_o      byte enables
//   st_dat_o   store data replicated across lanes
//   ld_dat_o   aligned, sign/zero-extended load data
//   mis_o      access is misaligned for its size
module load_store_align
  import stage_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_dat_i,
  input  logic [31:0] rd_dat_i,
  output logic [3:0]  sel_o,
  output logic [31:0] st_dat_o,
  output logic [31:0] ld_dat_o,
  output logic        mis_o
);

  logic [31:0] shifted;

  assign shifted = rd_dat_i >> {addr_lo_i, 3'b000};

  // funct3[1:0]: 00 byte, 01 half, anything else is handled as a word.
  always_comb begin
    sel_o    = 4'b1111;
    st_dat_o = st_dat_i;
    mis_o    = (addr_lo_i != 2'b00);
    case (funct3_i[1:0])
      2'b00: begin
        sel_o    = 4'b0001 << addr_lo_i;
        st_dat_o = {4{st_dat_i[7:0]}};
        mis_o    = 1'b0;
      end
      2'b01: begin
        sel_o    = 4'b0011 << addr_lo_i;
        st_dat_o = {2{st_dat_i[15:0]}};
        mis_o    = addr_lo_i[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_dat_o = rd_dat_i;
    case (funct3_i)
      F3_LB:  ld_dat_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:  ld_dat_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU: ld_dat_o = {24'd0, shifted[7:0]};
      F3_LHU: ld_dat_o = {16'd0, shifted[15:0]};
      default: ld_dat_o = rd_dat_i;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// stage_mem: RV32I memory-access stage between EX and WB.
// Issues one data-bus transaction per load/store, stalls EX while it is
// outstanding, detects misalignment / bus error / timeout and registers
// everything write-back needs.
// Ports:
//   clk_i, rst_i           clock, async active-low reset
//   valid_i .. flush_i     instruction and control from EX / WB
//   stall_o                hold EX inputs stable
//   dbus_*_o / dbus_*_i    data bus master (registered outputs)
//   valid_o .. e_*_o       registered results for WB
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  input  logic [31:0] alu_d_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs2_d_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic        e_illegal_inst_i,
  input  logic        e_inst_addr_mis_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_dat_o,
  output logic [3:0]  dbus_sel_o,
  output logic        dbus_we_o,
  output logic        dbus_cyc_o,
  input  logic [31:0] dbus_dat_i,
  input  logic        dbus_ack_i,
  input  logic        dbus_err_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o,
  output logic [2:0]  funct3_o,
  output logic [31:0] alu_d_o,
  output logic [31:0] mem_d_o,
  output logic [31:0] mem_addr_o,
  output logic        e_illegal_inst_o,
  output logic        e_inst_addr_mis_o,
  output logic        e_ld_addr_mis_o,
  output logic        e_st_addr_mis_o,
  output logic        e_ld_access_o,
  output logic        e_st_access_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  state_e        state_q;
  logic [CW-1:0] tcnt_q;
  logic          kill_q;

  logic [2:0]  al_f3;
  logic [1:0]  al_lo;
  logic [3:0]  al_sel;
  logic [31:0] al_st_dat;
  logic [31:0] al_ld_dat;
  logic        al_mis;
  logic        issue, timeout, resp, fault;

  // The WB copy of funct3/address is written at issue, so during BUS it
  // describes the access in flight even if EX changes after a flush.
  assign al_f3 = (state_q == ST_BUS) ? funct3_o : funct3_i;
  assign al_lo = (state_q == ST_BUS) ? alu_d_o[1:0] : alu_d_i[1:0];

  load_store_align u_align (
    .funct3_i  (al_f3),
    .addr_lo_i (al_lo),
    .st_dat_i  (rs2_d_i),
    .rd_dat_i  (dbus_dat_i),
    .sel_o     (al_sel),
    .st_dat_o  (al_st_dat),
    .ld_dat_o  (al_ld_dat),
    .mis_o     (al_mis)
  );

  assign issue = (state_q == ST_IDLE) && valid_i && (is_load_i || is_store_i) && !al_mis
                 && !e_illegal_inst_i && !e_inst_addr_mis_i && !flush_i;
  assign timeout = (state_q == ST_BUS) && (tcnt_q == TO_MAX);
  assign fault   = dbus_err_i || timeout;
  assign resp    = (state_q == ST_BUS) && (dbus_ack_i || fault);

  // Gated by reset so the stall is already low while reset is held.
  assign stall_o = rst_i && (issue || ((state_q == ST_BUS) && !resp));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q           <= ST_IDLE;
      tcnt_q            <= '0;
      kill_q            <= 1'b0;
      dbus_addr_o       <= '0;
      dbus_dat_o        <= '0;
      dbus_sel_o        <= '0;
      dbus_we_o         <= 1'b0;
      dbus_cyc_o        <= 1'b0;
      valid_o           <= 1'b0;
      pc_o              <= '0;
      instruction_o     <= '0;
      funct3_o          <= '0;
      alu_d_o           <= '0;
      mem_d_o           <= '0;
      mem_addr_o        <= '0;
      e_illegal_inst_o  <= 1'b0;
      e_inst_addr_mis_o <= 1'b0;
      e_ld_addr_mis_o   <= 1'b0;
      e_st_addr_mis_o   <= 1'b0;
      e_ld_access_o     <= 1'b0;
      e_st_access_o     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pc_o              <= pc_i;
          instruction_o     <= instruction_i;
          funct3_o          <= funct3_i;
          alu_d_o           <= alu_d_i;
          mem_addr_o        <= alu_d_i;
          mem_d_o           <= '0;
          e_illegal_inst_o  <= e_illegal_inst_i;
          e_inst_addr_mis_o <= e_inst_addr_mis_i;
          e_ld_addr_mis_o   <= valid_i && is_load_i && al_mis;
          e_st_addr_mis_o   <= valid_i && is_store_i && al_mis;
          e_ld_access_o     <= 1'b0;
          e_st_access_o     <= 1'b0;
          if (issue) begin
            valid_o     <= 1'b0;
            dbus_addr_o <= {alu_d_i[31:2], 2'b00};
            dbus_dat_o  <= al_st_dat;
            dbus_sel_o  <= al_sel;
            dbus_we_o   <= is_store_i;
            dbus_cyc_o  <= 1'b1;
            tcnt_q      <= '0;
            kill_q      <= 1'b0;
            state_q     <= ST_BUS;
          end else begin
            valid_o <= valid_i && !flush_i;
          end
        end
        ST_BUS: begin
          if (flush_i) kill_q <= 1'b1;
          if (resp) begin
            valid_o       <= !(kill_q || flush_i);
            mem_d_o       <= (!dbus_we_o && !fault) ? al_ld_dat : 32'd0;
            e_ld_access_o <= fault && !dbus_we_o;
            e_st_access_o <= fault && dbus_we_o;
            dbus_cyc_o    <= 1'b0;
            dbus_we_o     <= 1'b0;
            kill_q        <= 1'b0;
            state_q       <= ST_IDLE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
module tb_stage_mem;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] pc_i, instruction_i, alu_d_i, rs2_d_i;
  logic [2:0]  funct3_i;
  logic        is_load_i, is_store_i, e_illegal_inst_i, e_inst_addr_mis_i, flush_i;
  logic        stall_o;
  logic [31:0] dbus_addr_o, dbus_dat_o;
  logic [3:0]  dbus_sel_o;
  logic        dbus_we_o, dbus_cyc_o;
  logic [31:0] dbus_dat_i;
  logic        dbus_ack_i, dbus_err_i;
  logic        valid_o;
  logic [31:0] pc_o, instruction_o, alu_d_o, mem_d_o, mem_addr_o;
  logic [2:0]  funct3_o;
  logic        e_illegal_inst_o, e_inst_addr_mis_o, e_ld_addr_mis_o, e_st_addr_mis_o;
  logic        e_ld_access_o, e_st_access_o;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  stage_mem #(.TIMEOUT(255)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
    .instruction_i(instruction_i), .alu_d_i(alu_d_i), .funct3_i(funct3_i),
    .rs2_d_i(rs2_d_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
    .e_illegal_inst_i(e_illegal_inst_i), .e_inst_addr_mis_i(e_inst_addr_mis_i),
    .flush_i(flush_i), .stall_o(stall_o), .dbus_addr_o(dbus_addr_o),
    .dbus_dat_o(dbus_dat_o), .dbus_sel_o(dbus_sel_o), .dbus_we_o(dbus_we_o),
    .dbus_cyc_o(dbus_cyc_o), .dbus_dat_i(dbus_dat_i), .dbus_ack_i(dbus_ack_i),
    .dbus_err_i(dbus_err_i), .valid_o(valid_o), .pc_o(pc_o),
    .instruction_o(instruction_o), .funct3_o(funct3_o), .alu_d_o(alu_d_o),
    .mem_d_o(mem_d_o), .mem_addr_o(mem_addr_o),
    .e_illegal_inst_o(e_illegal_inst_o), .e_inst_addr_mis_o(e_inst_addr_mis_o),
    .e_ld_addr_mis_o(e_ld_addr_mis_o), .e_st_addr_mis_o(e_st_addr_mis_o),
    .e_ld_access_o(e_ld_access_o), .e_st_access_o(e_st_access_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    valid_i = 0; pc_i = 0; instruction_i = 0; alu_d_i = 0; rs2_d_i = 0;
    funct3_i = 0; is_load_i = 0; is_store_i = 0; e_illegal_inst_i = 0;
    e_inst_addr_mis_i = 0; flush_i = 0; dbus_dat_i = 0; dbus_ack_i = 0; dbus_err_i = 0;
  endtask

  task automatic drive_mem(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
    valid_i = 1; is_load_i = ld; is_store_i = !ld; funct3_i = f3; alu_d_i = addr;
    rs2_d_i = wd; pc_i = 32'h1000 + addr; instruction_i = 32'h00000003;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 0;
    step(); step();
    rst_i = 1;
    step();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    total++; if (dbus_cyc_o !== 1'b0) begin bad++; $display("FAIL reset_cyc got=%b exp=0", dbus_cyc_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    total++; if (mem_d_o !== 32'h0) begin bad++; $display("FAIL reset_memd got=%h exp=0", mem_d_o); end
    $display("reset: valid=%b cyc=%b stall=%b", valid_o, dbus_cyc_o, stall_o);
  endtask

  task automatic test_lw();
    drive_mem(1'b1, 3'b010, 32'h100, 32'h0);
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL lw_stall_issue got=%b exp=1", stall_o); end
    step();
    total++; if (dbus_cyc_o !== 1'b1 || dbus_sel_o !== 4'hF || dbus_addr_o !== 32'h100 || dbus_we_o !== 1'b0)
      begin bad++; $display("FAIL lw_bus got cyc=%b sel=%h addr=%h we=%b exp 1/f/100/0", dbus_cyc_o, dbus_sel_o, dbus_addr_o, dbus_we_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL lw_valid_early got=%b exp=0", valid_o); end
    dbus_ack_i = 1; dbus_dat_i = 32'hDEADBEEF;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL lw_stall_ack got=%b exp=0", stall_o); end
    step();
    clear_inputs();
    total++; if (valid_o !== 1'b1 || mem_d_o !== 32'hDEADBEEF)
      begin bad++; $display("FAIL lw_result got valid=%b memd=%h exp 1/deadbeef", valid_o, mem_d_o); end
    total++; if (dbus_cyc_o !== 1'b0 || pc_o !== 32'h1100)
      begin bad++; $display("FAIL lw_done got cyc=%b pc=%h exp 0/1100", dbus_cyc_o, pc_o); end
    $display("lw 0x100: memd=%h valid=%b", mem_d_o, valid_o);
  endtask

  task automatic byte_load(input logic [2:0] f3, input logic [31:0] exp_d, input string nm);
    drive_mem(1'b1, f3, 32'h103, 32'h0);
    step();
    total++; if (dbus_sel_o !== 4'b1000 || dbus_addr_o !== 32'h100)
      begin bad++; $display("FAIL %s_sel got sel=%b addr=%h exp 1000/100", nm, dbus_sel_o, dbus_addr_o); end
    dbus_ack_i = 1; dbus_dat_i = 32'h80FFFFFF;
    step();
    clear_inputs();
    total++; if (mem_d_o !== exp_d || valid_o !== 1'b1)
      begin bad++; $display("FAIL %s_data got=%h valid=%b exp=%h", nm, mem_d_o, valid_o, exp_d); end
    $display("%s 0x103: memd=%h", nm, mem_d_o);
  endtask

  task automatic test_lb_lbu();
    byte_load(3'b000, 32'hFFFFFF80, "lb");
    byte_load(3'b100, 32'h00000080, "lbu");
  endtask

  task automatic test_sh();
    drive_mem(1'b0, 3'b001, 32'h102, 32'h1234ABCD);
    step();
    total++; if (dbus_dat_o !== 32'hABCDABCD || dbus_sel_o !== 4'b1100 || dbus_we_o !== 1'b1 || dbus_cyc_o !== 1'b1)
      begin bad++; $display("FAIL sh_bus got dat=%h sel=%b we=%b cyc=%b exp abcdabcd/1100/1/1", dbus_dat_o, dbus_sel_o, dbus_we_o, dbus_cyc_o); end
    dbus_ack_i = 1;
    step();
    clear_inputs();
    total++; if (valid_o !== 1'b1 || mem_d_o !== 32'h0 || e_st_access_o !== 1'b0)
      begin bad++; $display("FAIL sh_done got valid=%b memd=%h acc=%b exp 1/0/0", valid_o, mem_d_o, e_st_access_o); end
    $display("sh 0x102: dat=%h", dbus_dat_o);
  endtask

  task automatic test_misaligned();
    drive_mem(1'b1, 3'b010, 32'h101, 32'h0);
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL mis_stall got=%b exp=0", stall_o); end
    step();
    clear_inputs();
    total++; if (valid_o !== 1'b1 || e_ld_addr_mis_o !== 1'b1 || mem_addr_o !== 32'h101 || dbus_cyc_o !== 1'b0)
      begin bad++; $display("FAIL mis_lw got valid=%b mis=%b addr=%h cyc=%b exp 1/1/101/0", valid_o, e_ld_addr_mis_o, mem_addr_o, dbus_cyc_o); end
    drive_mem(1'b0, 3'b001, 32'h201, 32'h0);
    step();
    clear_inputs();
    total++; if (e_st_addr_mis_o !== 1'b1 || e_ld_addr_mis_o !== 1'b0 || dbus_cyc_o !== 1'b0)
      begin bad++; $display("FAIL mis_sh got st=%b ld=%b cyc=%b exp 1/0/0", e_st_addr_mis_o, e_ld_addr_mis_o, dbus_cyc_o); end
    $display("misaligned: ld_mis/st_mis checked");
  endtask

  task automatic test_timeout();
    int n;
    drive_mem(1'b1, 3'b010, 32'h200, 32'h0);
    step();
    n = 1;
    while (stall_o === 1'b1 && n < 300) begin
      step();
      n++;
    end
    // Counter starts at 0 in the first BUS cycle and faults when it reads 255.
    total++; if (n !== 256) begin bad++; $display("FAIL timeout_cycles got=%0d exp=256", n); end
    step();
    clear_inputs();
    total++; if (e_ld_access_o !== 1'b1 || valid_o !== 1'b1 || mem_d_o !== 32'h0 || dbus_cyc_o !== 1'b0)
      begin bad++; $display("FAIL timeout_fault got acc=%b valid=%b memd=%h cyc=%b exp 1/1/0/0", e_ld_access_o, valid_o, mem_d_o, dbus_cyc_o); end
    $display("timeout: bus cycles=%0d", n);
  endtask

  task automatic test_err_ack();
    drive_mem(1'b1, 3'b010, 32'h300, 32'h0);
    step();
    dbus_ack_i = 1; dbus_err_i = 1; dbus_dat_i = 32'h12345678;
    step();
    clear_inputs();
    total++; if (e_ld_access_o !== 1'b1 || mem_d_o !== 32'h0 || e_st_access_o !== 1'b0)
      begin bad++; $display("FAIL err_ack got ld_acc=%b memd=%h st_acc=%b exp 1/0/0", e_ld_access_o, mem_d_o, e_st_access_o); end
    $display("err+ack: ld_access=%b", e_ld_access_o);
  endtask

  task automatic test_flush_store();
    drive_mem(1'b0, 3'b010, 32'h400, 32'hCAFEF00D);
    step();
    flush_i = 1;
    step();
    flush_i = 0;
    total++; if (dbus_cyc_o !== 1'b1 || dbus_dat_o !== 32'hCAFEF00D || dbus_we_o !== 1'b1)
      begin bad++; $display("FAIL flush_bus_held got cyc=%b dat=%h we=%b exp 1/cafef00d/1", dbus_cyc_o, dbus_dat_o, dbus_we_o); end
    dbus_ack_i = 1;
    step();
    clear_inputs();
    total++; if (valid_o !== 1'b0 || dbus_cyc_o !== 1'b0)
      begin bad++; $display("FAIL flush_killed got valid=%b cyc=%b exp 0/0", valid_o, dbus_cyc_o); end
    $display("flush in BUS: valid=%b", valid_o);
  endtask

  task automatic test_reset_mid();
    drive_mem(1'b1, 3'b010, 32'h500, 32'h0);
    step();
    total++; if (dbus_cyc_o !== 1'b1) begin bad++; $display("FAIL rmid_started got=%b exp=1", dbus_cyc_o); end
    #2;
    rst_i = 0;
    #1;
    total++; if (dbus_cyc_o !== 1'b0 || stall_o !== 1'b0 || dbus_addr_o !== 32'h0 || pc_o !== 32'h0 || valid_o !== 1'b0)
      begin bad++; $display("FAIL rmid_async got cyc=%b stall=%b addr=%h pc=%h valid=%b exp all 0", dbus_cyc_o, stall_o, dbus_addr_o, pc_o, valid_o); end
    clear_inputs();
    step();
    rst_i = 1;
    step();
    total++; if (dbus_cyc_o !== 1'b0 || valid_o !== 1'b0)
      begin bad++; $display("FAIL rmid_after got cyc=%b valid=%b exp 0/0", dbus_cyc_o, valid_o); end
    $display("reset mid-transaction: cyc=%b", dbus_cyc_o);
  endtask

  task automatic test_back_to_back();
    valid_i = 1; pc_i = 32'h40; alu_d_i = 32'h55; instruction_i = 32'h00000033; funct3_i = 3'b000;
    step();
    total++; if (valid_o !== 1'b1 || mem_d_o !== 32'h0 || mem_addr_o !== 32'h55 || pc_o !== 32'h40 || alu_d_o !== 32'h55)
      begin bad++; $display("FAIL alu_op got valid=%b memd=%h maddr=%h pc=%h alu=%h", valid_o, mem_d_o, mem_addr_o, pc_o, alu_d_o); end
    pc_i = 32'h44; flush_i = 1;
    step();
    total++; if (valid_o !== 1'b0 || pc_o !== 32'h44)
      begin bad++; $display("FAIL alu_flush got valid=%b pc=%h exp 0/44", valid_o, pc_o); end
    flush_i = 0; e_illegal_inst_i = 1; is_load_i = 1; funct3_i = 3'b010; alu_d_i = 32'h600;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL illegal_nostall got=%b exp=0", stall_o); end
    step();
    clear_inputs();
    total++; if (e_illegal_inst_o !== 1'b1 || dbus_cyc_o !== 1'b0 || valid_o !== 1'b1)
      begin bad++; $display("FAIL illegal_pass got ill=%b cyc=%b valid=%b exp 1/0/1", e_illegal_inst_o, dbus_cyc_o, valid_o); end
    $display("back-to-back non-memory ops checked");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_misaligned();
    test_timeout();
    test_err_ack();
    test_flush_store();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
